// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops plus bit-serial SLL/SRL
// behind a start/busy/done handshake, with registered result and flags.
module alu_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ctr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SLT = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLL = 3'b100,
        OP_SRL = 3'b101,
        OP_SUB = 3'b110,
        OP_XOR = 3'b111
    } op_e;

    state_e               state, state_n;
    logic [WIDTH-1:0]     acc, acc_n;
    logic [SHAMT_W-1:0]   cnt, cnt_n;
    logic                 dir_right, dir_right_n;
    logic [WIDTH-1:0]     result_q, result_n;
    logic                 zero_q, zero_n;
    logic                 ovf_q, ovf_n;
    logic                 done_q, done_n;

    op_e                  op;
    logic [SHAMT_W-1:0]   shamt;
    logic                 is_shift;
    logic [WIDTH-1:0]     sum, diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_ovf;
    logic [WIDTH-1:0]     acc_shifted;

    assign op       = op_e'(ctr);
    assign shamt    = b[SHAMT_W-1:0];
    assign is_shift = (op == OP_SLL) || (op == OP_SRL);
    assign sum      = a + b;
    assign diff     = a - b;

    // Single-cycle datapath; a shift only lands here when its amount is zero,
    // in which case the result is simply the unshifted operand.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would otherwise infer a latch.
        alu_res = a;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = a;
        endcase
    end

    assign acc_shifted = dir_right ? (acc >> 1) : (acc << 1);

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        dir_right_n = dir_right;
        result_n    = result_q;
        zero_n      = zero_q;
        ovf_n       = ovf_q;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_n       = a;
                        cnt_n       = shamt;
                        dir_right_n = (op == OP_SRL);
                        state_n     = SHIFT;
                    end else begin
                        result_n = alu_res;
                        zero_n   = (alu_res == '0);
                        ovf_n    = alu_ovf;
                        done_n   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                acc_n = acc_shifted;
                cnt_n = cnt - SHAMT_W'(1);
                // Last step: publish the shifted value directly, not acc, which
                // only picks it up on this same edge.
                if (cnt == SHAMT_W'(1)) begin
                    result_n = acc_shifted;
                    zero_n   = (acc_shifted == '0);
                    ovf_n    = 1'b0;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs, independent of statement order.
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            dir_right <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            dir_right <= dir_right_n;
            result_q  <= result_n;
            zero_q    <= zero_n;
            ovf_q     <= ovf_n;
            done_q    <= done_n;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign done     = done_q;
    assign busy     = (state == SHIFT);

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus randomized operations
// compared against a wide-integer reference model and a latency model.
module tb_alu_exec;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
    } op_t;

    op_t chain_q[$];

    alu_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ctr      (ctr),
        .a        (a),
        .b        (b),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: signed arithmetic in 64 bits, overflow = true result out of range.
    function automatic void ref_alu(input logic [2:0] op, input logic [31:0] av,
                                    input logic [31:0] bv, output logic [31:0] r,
                                    output logic o);
        longint sa;
        longint sb;
        longint wide;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        wide = 0;
        o = 1'b0;
        r = 32'h0;
        case (op)
            3'b000: wide = sa + sb;
            3'b110: wide = sa - sb;
            default: wide = 0;
        endcase
        case (op)
            3'b000, 3'b110: begin
                r = wide[31:0];
                o = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'b001: r = (sa < sb) ? 32'd1 : 32'd0;
            3'b010: r = av & bv;
            3'b011: r = av | bv;
            3'b100: r = av << bv[4:0];
            3'b101: r = av >> bv[4:0];
            default: r = av ^ bv;
        endcase
    endfunction

    // Called at a negedge with the DUT idle. inject>0 pulses start (ctr=ADD)
    // at that cycle while a shift is running; it must be ignored.
    task automatic run_op(input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input int inject);
        logic [31:0] er;
        logic        eo;
        int          k;
        int          lat;
        ref_alu(op, av, bv, er, eo);
        k   = int'(bv[4:0]);
        lat = ((op == 3'b100 || op == 3'b101) && k > 0) ? 1 + k : 1;
        start = 1'b1; ctr = op; a = av; b = bv;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check("busy", {31'b0, busy}, {31'b0, c < lat});
            check("done", {31'b0, done}, {31'b0, c == lat});
            if (c == lat) begin
                check("result", result, er);
                check("zero", {31'b0, zero}, {31'b0, er == 32'h0});
                check("overflow", {31'b0, overflow}, {31'b0, eo});
            end
            start = (c == inject && c < lat);
            ctr   = start ? 3'b000 : 3'($urandom);
            a     = $urandom;
            b     = $urandom;
        end
        start = 1'b0;
        @(negedge clk);
        check("done_drop", {31'b0, done}, 32'h0);
        check("busy_idle", {31'b0, busy}, 32'h0);
        check("result_hold", result, er);
    endtask

    // Issues chain_q back to back, start held high every cycle.
    task automatic run_chain();
        logic [31:0] er;
        logic        eo;
        for (int i = 0; i < chain_q.size(); i++) begin
            start = 1'b1; ctr = chain_q[i].op; a = chain_q[i].av; b = chain_q[i].bv;
            @(negedge clk);
            ref_alu(chain_q[i].op, chain_q[i].av, chain_q[i].bv, er, eo);
            check("b2b_done", {31'b0, done}, 32'h1);
            check("b2b_result", result, er);
            check("b2b_zero", {31'b0, zero}, {31'b0, er == 32'h0});
            check("b2b_overflow", {31'b0, overflow}, {31'b0, eo});
        end
        start = 1'b0;
        @(negedge clk);
        check("b2b_done_drop", {31'b0, done}, 32'h0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] rb;
        logic [2:0]  nonshift[6];
        nonshift = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

        rst_n = 1'b0; start = 1'b0; ctr = 3'b000; a = 32'h0; b = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'h0);
        check("rst_overflow", {31'b0, overflow}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);

        // Directed arithmetic and compare cases.
        run_op(3'b000, 32'h7FFF_FFFF, 32'h1, 0);
        run_op(3'b000, 32'hFFFF_FFFF, 32'h1, 0);
        run_op(3'b110, 32'd5, 32'd5, 0);
        run_op(3'b110, 32'h8000_0000, 32'h1, 0);
        run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 0);
        run_op(3'b001, 32'd3, 32'hFFFF_FFFE, 0);

        // Shift latency, high bits of b ignored, zero-amount shift.
        run_op(3'b100, 32'h1, 32'h25, 0);
        run_op(3'b101, 32'h8000_0000, 32'd31, 0);
        run_op(3'b100, 32'hDEAD_BEEF, 32'h20, 0);
        run_op(3'b101, 32'h1234_5678, 32'h0, 0);

        // ADD pulse during a k=4 shift must be dropped.
        run_op(3'b100, 32'h0000_0003, 32'd4, 2);

        // Back-to-back AND, OR, XOR.
        chain_q.delete();
        chain_q.push_back('{3'b010, 32'h0000_F0F0, 32'h0000_FF00});
        chain_q.push_back('{3'b011, 32'h0000_000F, 32'h0000_00F0});
        chain_q.push_back('{3'b111, 32'h0000_1234, 32'h0000_1234});
        run_chain();

        // Reset in the middle of a shift leaves no trace and no done.
        run_op(3'b000, 32'd3, 32'd4, 0);
        start = 1'b1; ctr = 3'b100; a = 32'h1; b = 32'd10;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            check("abort_busy", {31'b0, busy}, 32'h1);
            if (c == 4) rst_n = 1'b0;
        end
        @(negedge clk);
        check("abort_busy_clr", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_result", result, 32'h0);
        check("abort_zero", {31'b0, zero}, 32'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check("abort_no_done", {31'b0, done}, 32'h0);
        end

        // Random single operations, shifts with random ignored start pulses.
        for (int i = 0; i < 200; i++) begin
            rop = 3'($urandom);
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) rb[4:0] = 5'd0;
            run_op(rop, $urandom, rb, int'($urandom_range(0, 32)));
        end

        // Random back-to-back stream of single-cycle ops.
        chain_q.delete();
        for (int i = 0; i < 30; i++)
            chain_q.push_back('{nonshift[$urandom_range(0, 5)], $urandom, $urandom});
        run_chain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
